// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper board blocks: FSM states, cell field layout
// and the PRNG fallback seed.
package minesweeper_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_PLACE, ST_COUNT, ST_READY} state_t;

    localparam int          MINE_BIT     = 4;
    localparam int          COUNT_MSB    = 3;
    localparam logic [31:0] DEFAULT_SEED = 32'h12345678;
endpackage

// File: rtl/nbr_count8.sv
// Population count of eight neighbour mine bits; i_valid masks off-board neighbours.
module nbr_count8 (
    input  logic [7:0] i_mine,
    input  logic [7:0] i_valid,
    output logic [3:0] o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < 8; i++) begin
            o_count = o_count + {3'b000, i_mine[i] & i_valid[i]};
        end
    end
endmodule

// File: rtl/xor_shift.sv
// 32-bit xorshift PRNG step (13/17/5); purely combinational next-state function.
module xor_shift (
    input  logic [31:0] i_state,
    output logic [31:0] o_next
);
    logic [31:0] w_a;
    logic [31:0] w_b;

    assign w_a    = i_state ^ (i_state << 13);
    assign w_b    = w_a ^ (w_a >> 17);
    assign o_next = w_b ^ (w_b << 5);
endmodule

// File: rtl/board_gen.sv
// Mine-board generator: places mines in raster order, then stores 8-neighbour counts.
// Optional macro BOARD_SAFE_START_EN adds a mine-free 3x3 zone around (safe_x, safe_y).
module board_gen
    import minesweeper_pkg::*;
#(
    parameter int          x_size       = 16,
    parameter int          y_size       = 16,
    parameter int          x_coord_bits = 4,
    parameter int          y_coord_bits = 4,
    parameter logic [31:0] cutoff       = 32'h2AAAAAAA,
    parameter int          max_mines    = 40
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [31:0]                         seed_in,
    input  logic [x_coord_bits-1:0]             rd_x,
    input  logic [y_coord_bits-1:0]             rd_y,
`ifdef BOARD_SAFE_START_EN
    input  logic [x_coord_bits-1:0]             safe_x,
    input  logic [y_coord_bits-1:0]             safe_y,
`endif
    output logic [4:0]                          rd_data,
    output logic [x_coord_bits+y_coord_bits:0]  num_mines,
    output logic                                busy,
    output logic                                ready,
    output logic                                done
);
    localparam int                      NM_W   = x_coord_bits + y_coord_bits + 1;
    localparam logic [x_coord_bits-1:0] X_LAST = x_coord_bits'(x_size - 1);
    localparam logic [y_coord_bits-1:0] Y_LAST = y_coord_bits'(y_size - 1);
    localparam logic [NM_W-1:0]         MAX_M  = NM_W'(max_mines);

    state_t                  r_state;
    logic [31:0]             r_prng;
    logic [x_coord_bits-1:0] r_x;
    logic [y_coord_bits-1:0] r_y;
    logic                    r_mine  [y_size][x_size];
    logic [COUNT_MSB:0]      r_count [y_size][x_size];

    logic [31:0]             w_rand;
    logic                    w_safe_blk;
    logic                    w_is_mine;
    logic                    w_last_x;
    logic                    w_last;
    logic [x_coord_bits-1:0] w_xm, w_xp;
    logic [y_coord_bits-1:0] w_ym, w_yp;
    logic                    w_l, w_r, w_u, w_d;
    logic [7:0]              w_nbr;
    logic [7:0]              w_nbr_vld;
    logic [COUNT_MSB:0]      w_count;

    xor_shift u_prng (.i_state(r_prng), .o_next(w_rand));

`ifdef BOARD_SAFE_START_EN
    logic [x_coord_bits-1:0] r_sx;
    logic [y_coord_bits-1:0] r_sy;
    logic                    w_near_x, w_near_y;

    // Padded compares so +1 at the top coordinate does not wrap onto 0.
    always_comb begin
        w_near_x   = ({1'b0, r_x} == {1'b0, r_sx}) || ({1'b0, r_x} + 1'b1 == {1'b0, r_sx})
                  || ({1'b0, r_sx} + 1'b1 == {1'b0, r_x});
        w_near_y   = ({1'b0, r_y} == {1'b0, r_sy}) || ({1'b0, r_y} + 1'b1 == {1'b0, r_sy})
                  || ({1'b0, r_sy} + 1'b1 == {1'b0, r_y});
        w_safe_blk = w_near_x && w_near_y;
    end
`else
    assign w_safe_blk = 1'b0;
`endif

    assign w_is_mine = (w_rand <= cutoff) && (num_mines < MAX_M) && !w_safe_blk;
    assign w_last_x  = (r_x == X_LAST);
    assign w_last    = w_last_x && (r_y == Y_LAST);

    // Neighbour coordinates may wrap; the edge flags mask those reads out.
    assign w_xm = r_x - 1'b1;
    assign w_xp = r_x + 1'b1;
    assign w_ym = r_y - 1'b1;
    assign w_yp = r_y + 1'b1;
    assign w_l  = (r_x != '0);
    assign w_r  = (r_x != X_LAST);
    assign w_u  = (r_y != '0);
    assign w_d  = (r_y != Y_LAST);

    assign w_nbr = {r_mine[w_yp][w_xp], r_mine[w_yp][r_x], r_mine[w_yp][w_xm],
                    r_mine[r_y][w_xp],                     r_mine[r_y][w_xm],
                    r_mine[w_ym][w_xp], r_mine[w_ym][r_x], r_mine[w_ym][w_xm]};
    assign w_nbr_vld = {w_d && w_r, w_d, w_d && w_l,
                        w_r,             w_l,
                        w_u && w_r, w_u, w_u && w_l};

    nbr_count8 u_nbr (.i_mine(w_nbr), .i_valid(w_nbr_vld), .o_count(w_count));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            num_mines <= '0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_READY: begin
                    if (r_state == ST_READY) begin
                        ready <= 1'b1;
                        done  <= !ready;
                    end
                    if (start) begin
                        r_prng    <= (seed_in == 32'd0) ? DEFAULT_SEED : seed_in;
                        num_mines <= '0;
                        ready     <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        r_x       <= '0;
                        r_y       <= '0;
                        r_state   <= ST_PLACE;
`ifdef BOARD_SAFE_START_EN
                        r_sx      <= safe_x;
                        r_sy      <= safe_y;
`endif
                    end
                end
                ST_PLACE: begin
                    r_prng           <= w_rand;
                    r_mine[r_y][r_x] <= w_is_mine;
                    if (w_is_mine) begin
                        num_mines <= num_mines + 1'b1;
                    end
                    if (w_last) begin
                        r_state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    r_count[r_y][r_x] <= w_count;
                    if (w_last) begin
                        r_state <= ST_READY;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Raster cursor shared by PLACE and COUNT; restarts at (0,0) after the last cell.
            if (r_state == ST_PLACE || r_state == ST_COUNT) begin
                if (w_last) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (w_last_x) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_x <= X_LAST && rd_y <= Y_LAST) begin
            rd_data[MINE_BIT]    <= r_mine[rd_y][rd_x];
            rd_data[COUNT_MSB:0] <= r_count[rd_y][rd_x];
        end else begin
            rd_data <= '0;
        end
    end
endmodule

// File: tb/tb_board_gen.sv
// Randomised bench for board_gen: five configurations run side by side against a
// behavioural board model (xorshift sequence, raster placement, neighbour sums).
module tb_board_gen;
    localparam int NI = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [31:0] seed_in;
    logic [3:0]  rd_x, rd_y;
`ifdef BOARD_SAFE_START_EN
    logic [3:0]  safe_x, safe_y;
    localparam bit SAFE_ON = 1'b1;
`else
    localparam bit SAFE_ON = 1'b0;
`endif

    logic       done_a  [NI];
    logic       ready_a [NI];
    logic       busy_a  [NI];
    logic [4:0] rd_a    [NI];
    logic [8:0] nm0, nm1, nm2, nm3;
    logic [7:0] nm4;

    int n_chk  = 0;
    int n_pass = 0;

    logic       exp_mine [NI][16][16];
    logic [3:0] exp_cnt  [NI][16][16];
    int         exp_nm   [NI];

    board_gen u0 (.clk(clk), .reset(reset), .start(start), .seed_in(seed_in), .rd_x(rd_x), .rd_y(rd_y),
`ifdef BOARD_SAFE_START_EN
        .safe_x(safe_x), .safe_y(safe_y),
`endif
        .rd_data(rd_a[0]), .num_mines(nm0), .busy(busy_a[0]), .ready(ready_a[0]), .done(done_a[0]));

    board_gen #(.cutoff(32'hFFFFFFFF), .max_mines(256)) u1 (.clk(clk), .reset(reset), .start(start),
        .seed_in(seed_in), .rd_x(rd_x), .rd_y(rd_y),
`ifdef BOARD_SAFE_START_EN
        .safe_x(safe_x), .safe_y(safe_y),
`endif
        .rd_data(rd_a[1]), .num_mines(nm1), .busy(busy_a[1]), .ready(ready_a[1]), .done(done_a[1]));

    board_gen #(.cutoff(32'h0), .max_mines(40)) u2 (.clk(clk), .reset(reset), .start(start),
        .seed_in(seed_in), .rd_x(rd_x), .rd_y(rd_y),
`ifdef BOARD_SAFE_START_EN
        .safe_x(safe_x), .safe_y(safe_y),
`endif
        .rd_data(rd_a[2]), .num_mines(nm2), .busy(busy_a[2]), .ready(ready_a[2]), .done(done_a[2]));

    board_gen #(.cutoff(32'hFFFFFFFF), .max_mines(40)) u3 (.clk(clk), .reset(reset), .start(start),
        .seed_in(seed_in), .rd_x(rd_x), .rd_y(rd_y),
`ifdef BOARD_SAFE_START_EN
        .safe_x(safe_x), .safe_y(safe_y),
`endif
        .rd_data(rd_a[3]), .num_mines(nm3), .busy(busy_a[3]), .ready(ready_a[3]), .done(done_a[3]));

    board_gen #(.x_size(10), .y_size(6), .x_coord_bits(4), .y_coord_bits(3),
                .cutoff(32'h60000000), .max_mines(25)) u4 (.clk(clk), .reset(reset), .start(start),
        .seed_in(seed_in), .rd_x(rd_x), .rd_y(rd_y[2:0]),
`ifdef BOARD_SAFE_START_EN
        .safe_x(safe_x), .safe_y(safe_y[2:0]),
`endif
        .rd_data(rd_a[4]), .num_mines(nm4), .busy(busy_a[4]), .ready(ready_a[4]), .done(done_a[4]));

    function automatic int xs_of(input int k);
        return (k == 4) ? 10 : 16;
    endfunction

    function automatic int ys_of(input int k);
        return (k == 4) ? 6 : 16;
    endfunction

    function automatic logic [31:0] cut_of(input int k);
        case (k)
            0:       return 32'h2AAAAAAA;
            1, 3:    return 32'hFFFFFFFF;
            2:       return 32'h0;
            default: return 32'h60000000;
        endcase
    endfunction

    function automatic int max_of(input int k);
        case (k)
            1:       return 256;
            4:       return 25;
            default: return 40;
        endcase
    endfunction

    function automatic logic [31:0] nm_of(input int k);
        case (k)
            0:       return {23'd0, nm0};
            1:       return {23'd0, nm1};
            2:       return {23'd0, nm2};
            3:       return {23'd0, nm3};
            default: return {24'd0, nm4};
        endcase
    endfunction

    function automatic logic [31:0] xs32(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        t = t ^ (t << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic build_model(input int k, input logic [31:0] seed, input int sx, input int sy);
        logic [31:0] s;
        logic        m;
        int          n, c;
        s = (seed == 32'd0) ? 32'h12345678 : seed;
        n = 0;
        for (int y = 0; y < ys_of(k); y++) begin
            for (int x = 0; x < xs_of(k); x++) begin
                s = xs32(s);
                m = (s <= cut_of(k)) && (n < max_of(k));
                if (SAFE_ON && x >= sx - 1 && x <= sx + 1 && y >= sy - 1 && y <= sy + 1) m = 1'b0;
                exp_mine[k][y][x] = m;
                n += int'(m);
            end
        end
        exp_nm[k] = n;
        for (int y = 0; y < ys_of(k); y++) begin
            for (int x = 0; x < xs_of(k); x++) begin
                c = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < xs_of(k)
                            && y + dy >= 0 && y + dy < ys_of(k) && exp_mine[k][y+dy][x+dx])
                            c++;
                    end
                end
                exp_cnt[k][y][x] = 4'(c);
            end
        end
    endtask

    function automatic logic [4:0] exp_rd(input int k, input int x, input int y);
        int yy;
        yy = (k == 4) ? (y % 8) : y;
        if (x < xs_of(k) && yy < ys_of(k)) return {exp_mine[k][yy][x], exp_cnt[k][yy][x]};
        return 5'd0;
    endfunction

    task automatic pulse_start(input logic [31:0] seed, input int sx, input int sy);
        @(negedge clk);
        seed_in = seed;
`ifdef BOARD_SAFE_START_EN
        safe_x = 4'(sx);
        safe_y = 4'(sy);
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic read_at(input int x, input int y);
        @(negedge clk);
        rd_x = 4'(x);
        rd_y = 4'(y);
        @(posedge clk);
        #1;
    endtask

    // Runs one generation on all instances; an extra ignored start can be injected mid-run.
    task automatic do_run(input logic [31:0] seed, input int sx, input int sy,
                          input int ignore_at, input logic [31:0] seed2);
        int lat [NI];
        bit all_done;
        for (int k = 0; k < NI; k++) begin
            build_model(k, seed, sx, sy);
            lat[k] = -1;
        end
        pulse_start(seed, sx, sy);
        for (int cyc = 1; cyc <= 700; cyc++) begin
            if (cyc == ignore_at) begin
                @(negedge clk);
                seed_in = seed2;
                start   = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            all_done = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (done_a[k] && lat[k] < 0) lat[k] = cyc;
                if (lat[k] < 0) all_done = 1'b0;
            end
            if (all_done) break;
        end
        for (int k = 0; k < NI; k++)
            check($sformatf("done latency u%0d", k), lat[k], 2 * xs_of(k) * ys_of(k) + 1);
        @(posedge clk);
        #1;
        check("done pulse width u0", {31'd0, done_a[0]}, 32'd0);
        check("ready held u0", {31'd0, ready_a[0]}, 32'd1);
    endtask

    task automatic sweep();
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                read_at(x, y);
                for (int k = 0; k < NI; k++)
                    check($sformatf("rd u%0d (%0d,%0d)", k, x, y), {27'd0, rd_a[k]}, {27'd0, exp_rd(k, x, y)});
            end
        end
        for (int k = 0; k < NI; k++)
            check($sformatf("num_mines u%0d", k), nm_of(k), exp_nm[k]);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sd;
        int          sx, sy;
        reset   = 1'b1;
        start   = 1'b0;
        seed_in = 32'd0;
        rd_x    = 4'd0;
        rd_y    = 4'd0;
`ifdef BOARD_SAFE_START_EN
        safe_x  = 4'd0;
        safe_y  = 4'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset busy u%0d", k), {31'd0, busy_a[k]}, 32'd0);
            check($sformatf("reset ready u%0d", k), {31'd0, ready_a[k]}, 32'd0);
            check($sformatf("reset done u%0d", k), {31'd0, done_a[k]}, 32'd0);
            check($sformatf("reset num_mines u%0d", k), nm_of(k), 32'd0);
            check($sformatf("reset rd_data u%0d", k), {27'd0, rd_a[k]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Random seed, safe zone at the origin; fixed-value board facts follow the sweep.
        do_run($urandom | 32'h1, 0, 0, 0, 32'd0);
        sweep();
`ifdef BOARD_SAFE_START_EN
        check("u1 mines safe", nm_of(1), 32'd252);
        read_at(0, 0);
        check("u1 safe (0,0)", {27'd0, rd_a[1]}, 32'h00);
        read_at(1, 1);
        check("u1 safe (1,1)", {27'd0, rd_a[1]}, 32'h05);
`else
        check("u1 mines full", nm_of(1), 32'd256);
        read_at(0, 0);
        check("u1 corner", {27'd0, rd_a[1]}, 32'h13);
        read_at(5, 0);
        check("u1 edge", {27'd0, rd_a[1]}, 32'h15);
        read_at(7, 9);
        check("u1 interior", {27'd0, rd_a[1]}, 32'h18);
        check("u3 mines capped", nm_of(3), 32'd40);
        read_at(8, 2);
        check("u3 (8,2)", {27'd0, rd_a[3]}, 32'h04);
        read_at(0, 3);
        check("u3 (0,3)", {27'd0, rd_a[3]}, 32'h02);
        read_at(7, 2);
        check("u3 (7,2)", {27'd0, rd_a[3]}, 32'h14);
`endif
        check("u2 mines none", nm_of(2), 32'd0);
        read_at(12, 2);
        check("u4 x out of range", {27'd0, rd_a[4]}, 32'd0);
        read_at(3, 6);
        check("u4 y out of range", {27'd0, rd_a[4]}, 32'd0);

        // Zero seed must behave exactly like the fallback seed.
        sx = $urandom_range(9, 0);
        sy = $urandom_range(5, 0);
        do_run(32'd0, sx, sy, 0, 32'd0);
        sweep();
        do_run(32'h12345678, sx, sy, 0, 32'd0);
        sweep();

        // Reset in the middle of COUNT.
        sd = $urandom | 32'h1;
        for (int k = 0; k < NI; k++) build_model(k, sd, 0, 0);
        pulse_start(sd, 0, 0);
        repeat (300) @(posedge clk);
        #1;
        check("pre-reset busy u1", {31'd0, busy_a[1]}, 32'd1);
        check("pre-reset num_mines u1", nm_of(1), exp_nm[1]);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("midrun reset busy u%0d", k), {31'd0, busy_a[k]}, 32'd0);
            check($sformatf("midrun reset ready u%0d", k), {31'd0, ready_a[k]}, 32'd0);
            check($sformatf("midrun reset num_mines u%0d", k), nm_of(k), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Fresh start with a second start pulse during PLACE that must be ignored.
        sx = $urandom_range(9, 0);
        sy = $urandom_range(5, 0);
        do_run($urandom | 32'h1, sx, sy, 100, $urandom | 32'h1);
        sweep();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
